// File: rtl/cache_refill_controller.sv
// Cache refill controller: runs one CPU access at a time through a direct-mapped cache.
// On a miss it refills the whole block from memory first. Optional statistics: CACHE_STATS_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready=1, waiting for req
// LOOKUP   | address latched, sampling the tag-compare result
// MEM_WAIT | memory read of word word_cnt in flight (MEM_LAT cycles)
// FILL     | one-cycle cache write of the returned word
// READ     | one-cycle cache read, then back to IDLE
module cache_refill_controller #(
  parameter int ADDR_W  = 15,
  parameter int OFF_W   = 2,
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              hit,
  output logic              ready,
  output logic              cache_read,
  output logic              cache_write,
  output logic [OFF_W-1:0]  word_sel,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BLK_W = ADDR_W - OFF_W;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_WAIT = 3'd2,
    FILL     = 3'd3,
    READ     = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [OFF_W-1:0]  word_cnt;
  logic [OFF_W-1:0]  word_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [BLK_W-1:0]  blk;
  logic              unused_offset;

  assign blk      = addr_q[ADDR_W-1:OFF_W];
  assign word_nxt = word_cnt + OFF_W'(1);
  // The word offset of the request is irrelevant: refills always start at word 0.
  assign unused_offset = ^addr_q[OFF_W-1:0];

`ifdef CACHE_STATS_EN
  logic hit_q;
`endif

  // Outputs are registered alongside the state they belong to, so each one is
  // valid during the cycle the FSM spends in the corresponding state.
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      addr_q      <= '0;
      word_cnt    <= '0;
      lat_cnt     <= '0;
      ready       <= 1'b1;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
      word_sel    <= '0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
`ifdef CACHE_STATS_EN
      hit_q       <= 1'b0;
`endif
    end else begin
      ready       <= 1'b0;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
      word_sel    <= '0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= addr;
            state  <= LOOKUP;
          end else begin
            ready  <= 1'b1;
          end
        end
        LOOKUP: begin
`ifdef CACHE_STATS_EN
          hit_q <= hit;
`endif
          if (hit) begin
            state      <= READ;
            cache_read <= 1'b1;
          end else begin
            word_cnt <= '0;
            lat_cnt  <= '0;
            state    <= MEM_WAIT;
            mem_read <= 1'b1;
            mem_addr <= {blk, {OFF_W{1'b0}}};
          end
        end
        MEM_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state       <= FILL;
            cache_write <= 1'b1;
            word_sel    <= word_cnt;
          end else begin
            lat_cnt  <= lat_cnt + LAT_W'(1);
            mem_read <= 1'b1;
            mem_addr <= {blk, word_cnt};
          end
        end
        FILL: begin
          if (&word_cnt) begin
            state      <= READ;
            cache_read <= 1'b1;
          end else begin
            word_cnt <= word_nxt;
            lat_cnt  <= '0;
            state    <= MEM_WAIT;
            mem_read <= 1'b1;
            mem_addr <= {blk, word_nxt};
          end
        end
        READ: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] hit_cnt_nxt;
  logic [CNT_W-1:0] acc_cnt_nxt;

  // Saturating: a full counter holds its value rather than wrapping.
  always_comb begin
    acc_cnt_nxt = acc_cnt_q;
    hit_cnt_nxt = hit_cnt_q;
    if (acc_cnt_q != CNT_MAX) acc_cnt_nxt = acc_cnt_q + CNT_W'(1);
    if (hit_q && (hit_cnt_q != CNT_MAX)) hit_cnt_nxt = hit_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      hit_cnt_q <= '0;
      acc_cnt_q <= '0;
    end else if (state == READ) begin
      hit_cnt_q <= hit_cnt_nxt;
      acc_cnt_q <= acc_cnt_nxt;
      $display("cache_refill_controller: access_count=%0d hit_count=%0d",
               acc_cnt_nxt, hit_cnt_nxt);
    end
  end

  assign hit_count    = hit_cnt_q;
  assign access_count = acc_cnt_q;
`else
  assign hit_count    = '0;
  assign access_count = '0;
`endif

endmodule
